// File: rtl/cmd_link_if.sv
// ============================================================================
//  Module      : cmd_link_if
//  Description : Signal bundle for cmd_link. Carries the UART RX/TX handshake
//                and the command/response handshake with the command
//                processor.
//                  master : the environment around cmd_link (UART transceiver
//                           plus command processor)
//                  slave  : cmd_link itself
//  Signals     : rx_rdy/rx_data/clr_rx_rdy      UART RX byte handshake
//                trmt/tx_data/tx_done           UART TX byte handshake
//                cmd/cmd_rdy/clr_cmd_rdy        assembled 24-bit command
//                send_resp/resp_data/resp_sent  1-byte response request
//                frame_err                      partial frame dropped
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmd_link_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp_data;
  logic        resp_sent;
  logic        frame_err;

  modport master (
    output rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp_data,
    input  clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, resp_sent, frame_err
  );

  modport slave (
    input  rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp_data,
    output clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, resp_sent, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/cmd_link.sv
// ============================================================================
//  Module      : cmd_link
//  Description : Host-side end of the command/response link. Assembles three
//                UART RX bytes into a 24-bit command {byte1,byte2,byte3},
//                holds it with cmd_rdy until the consumer clears it, and
//                serialises 1-byte responses through the UART TX with a
//                resp_sent acknowledge. A partial frame that stalls for
//                TO_CYCLES cycles is dropped with a frame_err pulse.
//  Parameters  : TO_CYCLES  inter-byte timeout in clk cycles
//  Ports       : clk        system clock, all state on posedge
//                rst_n      asynchronous, active-low reset
//                bus        cmd_link_if.slave (UART + command handshakes)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_link #(
  parameter int TO_CYCLES = 1_000_000
) (
  input wire        clk,
  input wire        rst_n,
  cmd_link_if.slave bus
);

  localparam int c_cnt_w = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    B1   = 2'd0,
    B2   = 2'd1,
    B3   = 2'd2,
    HOLD = 2'd3
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  rx_state_t          r_rx_state;
  tx_state_t          r_tx_state;
  logic [23:0]        r_cmd;
  logic               r_cmd_rdy;
  logic               r_frame_err;
  logic [c_cnt_w-1:0] r_to_cnt;
  logic [7:0]         r_tx_data;
  logic               r_trmt;
  logic               r_resp_sent;

  logic               w_to_hit;

  assign w_to_hit = (r_to_cnt == c_to_last);

  // Byte consumption is combinational so the UART sees the clear in the same
  // cycle the byte is sampled. In HOLD the byte is left pending, which is the
  // backpressure towards the UART. Forced low while reset is asserted.
  assign bus.clr_rx_rdy = rst_n & bus.rx_rdy & (r_rx_state != HOLD);

  // --------------------------------------------------------------------------
  // RX path: frame assembly and inter-byte timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= B1;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
      r_frame_err <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_rx_state)
        B1: begin
          r_to_cnt <= '0;
          if (bus.rx_rdy) begin
            r_cmd[23:16] <= bus.rx_data;
            r_rx_state   <= B2;
          end
        end
        B2: begin
          // An arriving byte takes priority over an expiring timeout.
          if (bus.rx_rdy) begin
            r_cmd[15:8] <= bus.rx_data;
            r_to_cnt    <= '0;
            r_rx_state  <= B3;
          end else if (w_to_hit) begin
            r_frame_err <= 1'b1;
            r_to_cnt    <= '0;
            r_rx_state  <= B1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        B3: begin
          if (bus.rx_rdy) begin
            r_cmd[7:0] <= bus.rx_data;
            r_cmd_rdy  <= 1'b1;
            r_to_cnt   <= '0;
            r_rx_state <= HOLD;
          end else if (w_to_hit) begin
            r_frame_err <= 1'b1;
            r_to_cnt    <= '0;
            r_rx_state  <= B1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        HOLD: begin
          // cmd is frozen; only the consumer's clear releases the frame.
          r_to_cnt <= '0;
          if (bus.clr_cmd_rdy) begin
            r_cmd_rdy  <= 1'b0;
            r_rx_state <= B1;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // TX path: one response byte in flight at a time
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_data   <= '0;
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (bus.send_resp) begin
            r_tx_data  <= bus.resp_data;
            r_trmt     <= 1'b1;
            r_tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          // tx_data stays untouched here so the UART sees a stable byte.
          if (bus.tx_done) begin
            r_resp_sent <= 1'b1;
            r_tx_state  <= TX_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cmd       = r_cmd;
  assign bus.cmd_rdy   = r_cmd_rdy;
  assign bus.frame_err = r_frame_err;
  assign bus.tx_data   = r_tx_data;
  assign bus.trmt      = r_trmt;
  assign bus.resp_sent = r_resp_sent;

endmodule

`default_nettype wire

// File: tb/tb_cmd_link.sv
// ============================================================================
//  Module      : tb_cmd_link
//  Description : Scoreboard bench for cmd_link. Stimulus pushes expected
//                commands, TX bytes, resp_sent and frame_err events into
//                queues; a monitor pops and compares them whenever the DUT
//                presents the corresponding output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_link;

  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cmd_link_if bus();

  cmd_link #(.TO_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_pulses = 0;

  logic [23:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_resp_q[$];
  int          exp_ferr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected no such event", name, act);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: samples 1 time unit after each negedge
  // --------------------------------------------------------------------------
  logic       prev_cmd_rdy = 1'b0, prev_trmt = 1'b0, prev_resp = 1'b0;
  logic       prev_ferr = 1'b0, prev_clr = 1'b0;
  logic       tx_busy = 1'b0, tx_unstable = 1'b0;
  logic [7:0] tx_hold = 8'h00;

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      tx_busy     = 1'b0;
      tx_unstable = 1'b0;
    end
    if (bus.cmd_rdy && !prev_cmd_rdy) begin
      if (exp_cmd_q.size() == 0) flag("unexpected cmd_rdy", {8'h00, bus.cmd});
      else chk("scoreboard cmd", {8'h00, bus.cmd}, {8'h00, exp_cmd_q.pop_front()});
    end
    if (bus.trmt) begin
      if (prev_trmt) flag("trmt wider than 1 cycle", 32'(bus.trmt));
      else if (exp_tx_q.size() == 0) flag("unexpected trmt", 32'(bus.tx_data));
      else chk("scoreboard tx_data", 32'(bus.tx_data), 32'(exp_tx_q.pop_front()));
      tx_hold = bus.tx_data;
      tx_busy = 1'b1;
    end
    if (tx_busy && (bus.tx_data !== tx_hold)) tx_unstable = 1'b1;
    if (bus.resp_sent) begin
      if (prev_resp) flag("resp_sent wider than 1 cycle", 32'(bus.resp_sent));
      else if (exp_resp_q.size() == 0) flag("unexpected resp_sent", 32'(bus.resp_sent));
      else begin
        void'(exp_resp_q.pop_front());
        chk("tx_data stable while busy", 32'(tx_unstable), 32'd0);
      end
      tx_busy     = 1'b0;
      tx_unstable = 1'b0;
    end
    if (bus.frame_err) begin
      if (prev_ferr) flag("frame_err wider than 1 cycle", 32'(bus.frame_err));
      else if (exp_ferr_q.size() == 0) flag("unexpected frame_err", 32'(bus.frame_err));
      else void'(exp_ferr_q.pop_front());
    end
    if (bus.clr_rx_rdy && !prev_clr) rx_pulses++;
    prev_cmd_rdy = bus.cmd_rdy;
    prev_trmt    = bus.trmt;
    prev_resp    = bus.resp_sent;
    prev_ferr    = bus.frame_err;
    prev_clr     = bus.clr_rx_rdy;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge)
  // --------------------------------------------------------------------------
  task automatic wait_accept(input string name);
    int n;
    n = 0;
    #1;
    while (bus.clr_rx_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.clr_rx_rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: clr_rx_rdy=%b after 200 cycles, expected 1", name, bus.clr_rx_rdy);
    end
    @(negedge clk);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    wait_accept("rx byte accept");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic consume();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " cmd"},       {8'h00, bus.cmd}, 32'h0);
    chk({tag, " cmd_rdy"},   32'(bus.cmd_rdy),   32'h0);
    chk({tag, " tx_data"},   32'(bus.tx_data),   32'h0);
    chk({tag, " trmt"},      32'(bus.trmt),      32'h0);
    chk({tag, " resp_sent"}, 32'(bus.resp_sent), 32'h0);
    chk({tag, " frame_err"}, 32'(bus.frame_err), 32'h0);
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  int   p0;
  logic hold_bad;

  initial begin
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.tx_done     = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp_data   = 8'h00;
    rst_n           = 1'b0;

    // Reset state, with a pending RX byte that must not be consumed
    repeat (3) @(negedge clk);
    bus.rx_rdy = 1'b1;
    #1;
    check_reset_values("reset");
    chk("reset clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'h0);
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    rst_n      = 1'b1;
    idle(2);

    // 1: basic frame with idle gaps
    p0 = rx_pulses;
    exp_cmd_q.push_back(24'h021D00);
    send_byte(8'h02);
    idle(3);
    send_byte(8'h1D);
    idle(4);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h00;
    #1;
    chk("cmd_rdy before byte3 edge", 32'(bus.cmd_rdy), 32'h0);
    wait_accept("byte3");
    #1;
    chk("cmd_rdy latency", 32'(bus.cmd_rdy), 32'h1);
    chk("cmd frame1", {8'h00, bus.cmd}, 32'h00021D00);
    idle(1);
    chk("clr_rx_rdy pulse count", 32'(rx_pulses - p0), 32'd3);

    // 2: 4th byte while holding; taken as byte1 after clr_cmd_rdy
    exp_cmd_q.push_back(24'h051122);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h05;
    hold_bad    = 1'b0;
    repeat (6) begin
      #1;
      if (bus.clr_rx_rdy !== 1'b0 || bus.cmd !== 24'h021D00 || bus.cmd_rdy !== 1'b1) hold_bad = 1'b1;
      @(negedge clk);
    end
    chk("hold backpressure and freeze", 32'(hold_bad), 32'h0);
    consume();
    wait_accept("byte1 after hold");
    #1;
    chk("byte1 after hold, lower bytes kept", {8'h00, bus.cmd}, 32'h00051D00);
    chk("cmd_rdy cleared", 32'(bus.cmd_rdy), 32'h0);
    @(negedge clk);
    send_byte(8'h11);
    idle(2);
    send_byte(8'h22);
    consume();
    idle(2);

    // 3: timeout after byte1
    send_byte(8'h04);
    exp_ferr_q.push_back(1);
    repeat (15) @(negedge clk);
    #1;
    chk("no frame_err before limit", 32'(bus.frame_err), 32'h0);
    @(negedge clk);
    #1;
    chk("frame_err at limit", 32'(bus.frame_err), 32'h1);
    chk("cmd_rdy after timeout", 32'(bus.cmd_rdy), 32'h0);
    @(negedge clk);
    exp_cmd_q.push_back(24'h062100);
    send_byte(8'h06);
    idle(1);
    send_byte(8'h21);
    idle(1);
    send_byte(8'h00);
    consume();
    idle(2);

    // 4: byte2 arriving in the exact timeout cycle wins
    exp_cmd_q.push_back(24'h07AA55);
    send_byte(8'h07);
    repeat (15) @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'hAA;
    #1;
    chk("byte in limit cycle accepted", 32'(bus.clr_rx_rdy), 32'h1);
    wait_accept("byte2 at limit");
    #1;
    chk("byte2 at limit stored", 32'(bus.cmd[15:8]), 32'hAA);
    chk("no frame_err on late byte", 32'(bus.frame_err), 32'h0);
    @(negedge clk);
    send_byte(8'h55);
    consume();
    idle(2);

    // 5: response path
    exp_tx_q.push_back(8'hA5);
    bus.send_resp = 1'b1;
    bus.resp_data = 8'hA5;
    @(negedge clk);
    bus.send_resp = 1'b0;
    bus.resp_data = 8'h00;
    #1;
    chk("trmt latency", 32'(bus.trmt), 32'h1);
    chk("tx_data A5", 32'(bus.tx_data), 32'hA5);
    idle(5);
    bus.send_resp = 1'b1;
    bus.resp_data = 8'h3C;
    @(negedge clk);
    bus.send_resp = 1'b0;
    idle(43);
    exp_resp_q.push_back(1);
    bus.tx_done = 1'b1;
    #1;
    chk("resp_sent not early", 32'(bus.resp_sent), 32'h0);
    @(negedge clk);
    bus.tx_done = 1'b0;
    #1;
    chk("resp_sent latency", 32'(bus.resp_sent), 32'h1);
    chk("tx_data held through busy", 32'(bus.tx_data), 32'hA5);
    @(negedge clk);
    pulse_tx_done();
    idle(3);

    // 6: RX and TX together, then reset in B3 / TX_BUSY
    exp_tx_q.push_back(8'h5A);
    bus.rx_rdy    = 1'b1;
    bus.rx_data   = 8'h08;
    bus.send_resp = 1'b1;
    bus.resp_data = 8'h5A;
    #1;
    chk("simultaneous rx accept", 32'(bus.clr_rx_rdy), 32'h1);
    @(negedge clk);
    bus.rx_rdy    = 1'b0;
    bus.send_resp = 1'b0;
    #1;
    chk("simultaneous trmt", 32'(bus.trmt), 32'h1);
    @(negedge clk);
    send_byte(8'h09);
    idle(1);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid-op reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    pulse_tx_done();
    idle(2);
    exp_cmd_q.push_back(24'h0A0B0C);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h0C);
    #1;
    chk("cmd after reset", {8'h00, bus.cmd}, 32'h000A0B0C);
    @(negedge clk);
    consume();
    exp_tx_q.push_back(8'hC3);
    bus.send_resp = 1'b1;
    bus.resp_data = 8'hC3;
    @(negedge clk);
    bus.send_resp = 1'b0;
    #1;
    chk("trmt after reset", 32'(bus.trmt), 32'h1);
    @(negedge clk);
    idle(4);
    exp_resp_q.push_back(1);
    pulse_tx_done();
    idle(5);

    chk("cmd queue drained",  32'(exp_cmd_q.size()),  32'd0);
    chk("tx queue drained",   32'(exp_tx_q.size()),   32'd0);
    chk("resp queue drained", 32'(exp_resp_q.size()), 32'd0);
    chk("ferr queue drained", 32'(exp_ferr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
